// File: rtl/vwiden_pkg.sv
// Shared types and constants for the vector widening issue stage.
package vwiden_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TURN0 = 2'd1,
        TURN1 = 2'd2
    } state_e;

    localparam logic [1:0] SEW8  = 2'd0;
    localparam logic [1:0] SEW16 = 2'd1;
    localparam logic [1:0] SEW32 = 2'd2;
    localparam logic [1:0] SEW64 = 2'd3;

    // Widest source SEW that can still be doubled.
    localparam logic [1:0] SEW_MAX_WIDEN = SEW32;

endpackage

// File: rtl/vwiden_issue.sv
// Issue stage for the widening unit: holds one source beat and replays it as lower/upper turns.
// Optional WIDEN_SKIP_EMPTY_HALF_EN skips turns whose byte-enable half is all zero.
module vwiden_issue
    import vwiden_pkg::*;
#(
    parameter int REQ_DATA_WIDTH    = 64,
    parameter int SEW_WIDTH         = 2,
    parameter int REQ_BYTE_EN_WIDTH = REQ_DATA_WIDTH / 8,
    parameter int ADDR_WIDTH        = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [REQ_DATA_WIDTH-1:0]    in_vec,
    input  logic [REQ_BYTE_EN_WIDTH-1:0] in_be,
    input  logic [SEW_WIDTH-1:0]         in_sew,
    input  logic                         in_signed,
    input  logic [ADDR_WIDTH-1:0]        in_addr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [REQ_DATA_WIDTH-1:0]    out_vec,
    output logic [REQ_BYTE_EN_WIDTH-1:0] out_be,
    output logic [SEW_WIDTH-1:0]         out_sew,
    output logic                         out_signed,
    output logic                         out_turn,
    output logic [ADDR_WIDTH-1:0]        out_addr,
    output logic                         out_last,
    output logic                         err_sew
);

    state_e                         state_q, state_d;
    logic [REQ_DATA_WIDTH-1:0]      vec_q, vec_d;
    logic [REQ_BYTE_EN_WIDTH-1:0]   be_q, be_d;
    logic [SEW_WIDTH-1:0]           sew_q, sew_d;
    logic                           signed_q, signed_d;
    logic [ADDR_WIDTH-1:0]          addr_q, addr_d;
    logic                           err_sew_q, err_sew_d;

    logic   last_beat;
    logic   accept;
    state_e first_state;

`ifdef WIDEN_SKIP_EMPTY_HALF_EN
    localparam int HALF = REQ_BYTE_EN_WIDTH / 2;

    logic in_lo_any, in_hi_any, held_hi_any;
    assign in_lo_any   = |in_be[HALF-1:0];
    assign in_hi_any   = |in_be[REQ_BYTE_EN_WIDTH-1:HALF];
    assign held_hi_any = |be_q[REQ_BYTE_EN_WIDTH-1:HALF];

    // A fully disabled beat maps to IDLE, i.e. it is silently dropped.
    always_comb begin
        first_state = in_lo_any ? TURN0 : (in_hi_any ? TURN1 : IDLE);
        last_beat   = (state_q == TURN1) || ((state_q == TURN0) && !held_hi_any);
    end
`else
    always_comb begin
        first_state = TURN0;
        last_beat   = (state_q == TURN1);
    end
`endif

    assign in_ready = (state_q == IDLE) || (last_beat && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        be_d      = be_q;
        sew_d     = sew_q;
        signed_d  = signed_q;
        addr_d    = addr_q;
        err_sew_d = 1'b0;

        if (state_q != IDLE && out_ready) begin
            state_d = last_beat ? IDLE : TURN1;
        end

        // A new accept overrides the consume transition so vectors stream back to back.
        if (accept) begin
            vec_d    = in_vec;
            be_d     = in_be;
            sew_d    = in_sew;
            signed_d = in_signed;
            addr_d   = in_addr;
            if (in_sew > SEW_WIDTH'(SEW_MAX_WIDEN)) begin
                err_sew_d = 1'b1;
                state_d   = IDLE;
            end else begin
                state_d = first_state;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            vec_q     <= '0;
            be_q      <= '0;
            sew_q     <= '0;
            signed_q  <= 1'b0;
            addr_q    <= '0;
            err_sew_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            be_q      <= be_d;
            sew_q     <= sew_d;
            signed_q  <= signed_d;
            addr_q    <= addr_d;
            err_sew_q <= err_sew_d;
        end
    end

    assign out_valid  = (state_q != IDLE);
    assign out_turn   = (state_q == TURN1);
    assign out_last   = last_beat;
    assign out_vec    = vec_q;
    assign out_be     = be_q;
    assign out_sew    = sew_q;
    assign out_signed = signed_q;
    assign out_addr   = addr_q + ADDR_WIDTH'(out_turn);
    assign err_sew    = err_sew_q;

endmodule

// File: tb/tb_vwiden_issue.sv
// Self-checking bench for vwiden_issue: directed test-plan sequences plus random traffic
// against a queue-of-expected-beats model. Honours WIDEN_SKIP_EMPTY_HALF_EN.
module tb_vwiden_issue;

    localparam int DW = 64;
    localparam int SW = 2;
    localparam int BW = DW / 8;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_vec;
    logic [BW-1:0] in_be;
    logic [SW-1:0] in_sew;
    logic          in_signed;
    logic [AW-1:0] in_addr;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_vec;
    logic [BW-1:0] out_be;
    logic [SW-1:0] out_sew;
    logic          out_signed;
    logic          out_turn;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          err_sew;

    always #5 clk = ~clk;

    vwiden_issue #(
        .REQ_DATA_WIDTH    (DW),
        .SEW_WIDTH         (SW),
        .REQ_BYTE_EN_WIDTH (BW),
        .ADDR_WIDTH        (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vec     (in_vec),
        .in_be      (in_be),
        .in_sew     (in_sew),
        .in_signed  (in_signed),
        .in_addr    (in_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_vec    (out_vec),
        .out_be     (out_be),
        .out_sew    (out_sew),
        .out_signed (out_signed),
        .out_turn   (out_turn),
        .out_addr   (out_addr),
        .out_last   (out_last),
        .err_sew    (err_sew)
    );

    typedef struct {
        logic [DW-1:0] vec;
        logic [BW-1:0] be;
        logic [SW-1:0] sew;
        logic          sgn;
        logic          turn;
        logic [AW-1:0] addr;
        logic          last;
    } beat_t;

    beat_t q[$];
    logic  err_exp   = 1'b0;
    bit    after_rst = 1'b0;
    int    n_tests   = 0;
    int    n_fail    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic beat_t mk(input logic [DW-1:0] vec, input logic [BW-1:0] be,
                                 input logic [SW-1:0] sew, input logic sg,
                                 input logic [AW-1:0] base, input logic turn, input logic last);
        beat_t b;
        logic [AW-1:0] a;
        a      = base + AW'(turn);
        b.vec  = vec;
        b.be   = be;
        b.sew  = sew;
        b.sgn  = sg;
        b.turn = turn;
        b.addr = a;
        b.last = last;
        return b;
    endfunction

    task automatic push_beats(input logic [DW-1:0] vec, input logic [BW-1:0] be,
                              input logic [SW-1:0] sew, input logic sg, input logic [AW-1:0] a);
`ifdef WIDEN_SKIP_EMPTY_HALF_EN
        logic lo, hi;
        lo = |be[BW/2-1:0];
        hi = |be[BW-1:BW/2];
        if (lo) q.push_back(mk(vec, be, sew, sg, a, 1'b0, !hi));
        if (hi) q.push_back(mk(vec, be, sew, sg, a, 1'b1, 1'b1));
`else
        q.push_back(mk(vec, be, sew, sg, a, 1'b0, 1'b0));
        q.push_back(mk(vec, be, sew, sg, a, 1'b1, 1'b1));
`endif
    endtask

    // One clock cycle: drive, check at mid-cycle against the model, advance the model, clock.
    task automatic cyc(input logic v, input logic [DW-1:0] vec, input logic [BW-1:0] be,
                       input logic [SW-1:0] sew, input logic sg, input logic [AW-1:0] a,
                       input logic ordy, input logic r);
        logic exp_ready;
        rst       = r;
        in_valid  = v;
        in_vec    = vec;
        in_be     = be;
        in_sew    = sew;
        in_signed = sg;
        in_addr   = a;
        out_ready = ordy;
        #4;
        exp_ready = (q.size() == 0) || (q.size() == 1 && ordy);
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        check("out_valid", 64'(out_valid), 64'(q.size() != 0));
        check("err_sew", 64'(err_sew), 64'(err_exp));
        if (q.size() != 0 && out_valid) begin
            check("out_vec", out_vec, q[0].vec);
            check("out_be", 64'(out_be), 64'(q[0].be));
            check("out_sew", 64'(out_sew), 64'(q[0].sew));
            check("out_signed", 64'(out_signed), 64'(q[0].sgn));
            check("out_turn", 64'(out_turn), 64'(q[0].turn));
            check("out_addr", 64'(out_addr), 64'(q[0].addr));
            check("out_last", 64'(out_last), 64'(q[0].last));
        end else if (after_rst) begin
            check("rst_vec", out_vec, 64'd0);
            check("rst_be", 64'(out_be), 64'd0);
            check("rst_sew", 64'(out_sew), 64'd0);
            check("rst_signed", 64'(out_signed), 64'd0);
            check("rst_turn", 64'(out_turn), 64'd0);
            check("rst_addr", 64'(out_addr), 64'd0);
            check("rst_last", 64'(out_last), 64'd0);
        end
        if (r) begin
            q.delete();
            err_exp   = 1'b0;
            after_rst = 1'b1;
        end else begin
            if (q.size() != 0 && ordy) void'(q.pop_front());
            err_exp = 1'b0;
            if (v && exp_ready) begin
                after_rst = 1'b0;
                if (sew == 2'd3) err_exp = 1'b1;
                else push_beats(vec, be, sew, sg, a);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] rv;
        logic [BW-1:0] rbe;
        logic [SW-1:0] rsew;
        int            k;

        rst = 1'b1; in_valid = 1'b0; in_vec = '0; in_be = '0; in_sew = '0;
        in_signed = 1'b0; in_addr = '0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        after_rst = 1'b1;

        cyc(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
        idle(1);

        // Single beat
        cyc(1'b1, 64'h8877665544332211, 8'hFF, 2'd0, 1'b0, 5'd4, 1'b1, 1'b0);
        idle(3);

        // Back-to-back: three beats, data changes per accepted beat
        for (int i = 0; i < 6; i++)
            cyc(1'b1, 64'h1000 + 64'(i / 2), 8'hFF, 2'(i / 2), 1'(i), 5'(10 + i / 2), 1'b1, 1'b0);
        idle(2);

        // Back-pressure in TURN0, then release
        cyc(1'b1, 64'hDEADBEEFCAFEF00D, 8'hFF, 2'd1, 1'b1, 5'd7, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 64'h1, 8'hFF, 2'd0, 1'b0, 5'd1, 1'b0, 1'b0);
        idle(3);

        // Illegal SEW
        cyc(1'b1, 64'hABCD, 8'hFF, 2'd3, 1'b0, 5'd2, 1'b1, 1'b0);
        idle(2);

        // Address wrap
        cyc(1'b1, 64'h5555AAAA5555AAAA, 8'hFF, 2'd2, 1'b1, 5'd31, 1'b1, 1'b0);
        idle(3);

        // Reset while TURN1 is stalled
        cyc(1'b1, 64'h0123456789ABCDEF, 8'hFF, 2'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        cyc(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        idle(3);

        // Partial byte enables (both halves issued unless the skip feature is built in)
        cyc(1'b1, 64'h0F0F0F0F0F0F0F0F, 8'h0F, 2'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        idle(3);
        cyc(1'b1, 64'h00000000FFFFFFFF, 8'h00, 2'd1, 1'b0, 5'd6, 1'b1, 1'b0);
        idle(3);
        cyc(1'b1, 64'hF0F0F0F0F0F0F0F0, 8'hF0, 2'd2, 1'b1, 5'd31, 1'b1, 1'b0);
        idle(3);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            rv = {$urandom, $urandom};
            k  = $urandom_range(0, 7);
            case (k)
                0:       rbe = 8'h00;
                1:       rbe = {4'h0, 4'($urandom_range(1, 15))};
                2:       rbe = {4'($urandom_range(1, 15)), 4'h0};
                default: rbe = 8'($urandom);
            endcase
            rsew = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            cyc(1'($urandom_range(0, 3) != 0), rv, rbe, rsew, 1'($urandom),
                5'($urandom), 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 79) == 0));
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
